rv32i_core: RTL and testbench

Single-cycle RV32I processor with Zicsr support, a small machine-mode CSR file and an internal unified instruction/data RAM. It is the top-level compute block. Software is preloaded into the RAM array by the bench before reset is released. Each clock retires one instruction, and the program counter is exported for observation.

---
 rtl/rv32i_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_rv32i_core.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_core.sv
// Single-cycle RV32I + Zicsr core with a machine-mode CSR file and an internal unified RAM.
// One instruction retires per rising edge; instruction fetch and load data are read combinationally.

module rv32i_ram #(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] iidx_i,
  output logic [31:0]   idata_o,
  input  logic [AW-1:0] didx_i,
  output logic [31:0]   drdata_o,
  input  logic          we_i,
  input  logic [3:0]    wstrb_i,
  input  logic [31:0]   wdata_i
);
  logic [31:0] mem [MEM_WORDS];

  assign idata_o  = mem[iidx_i];
  assign drdata_o = mem[didx_i];

  // NOTE: the array has no reset; it is preloaded before reset release and must survive resets.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem[didx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end
endmodule

module rv32i_core #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] pc
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67,
                         OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23,
                         OPC_OPIMM = 7'h13, OPC_OP = 7'h33, OPC_SYSTEM = 7'h73;

  logic        reset;
  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3, alu_fn;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [31:0] rf_q [32];
  logic [31:0] rs1_val, rs2_val, alu_x, alu_y, alu_res;
  logic        alu_alt, br_taken;
  logic [31:0] ram_d_addr, ram_rdata, ld_shift, load_data, st_data;
  logic [4:0]  lane_sh;
  logic [3:0]  st_strb;
  logic        ram_w_enable, reg_w_enable, wb_en;
  logic [4:0]  reg_write_idx;
  logic [31:0] reg_wdata;
  logic        csr_we, csr_re, is_csr, is_ecall, is_mret;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_data_1, csr_old, csr_new;
  logic [31:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q, cycle_q;
  logic        unused_ok;

  assign reset    = reset_n;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  rv32i_ram #(.MEM_WORDS(MEM_WORDS), .AW(AW)) ram (
    .clk(clk), .iidx_i(pc_q[AW+1:2]), .idata_o(instr), .didx_i(ram_d_addr[AW+1:2]),
    .drdata_o(ram_rdata), .we_i(ram_w_enable), .wstrb_i(st_strb), .wdata_i(st_data)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    imm = imm_i;
    case (opcode)
      OPC_STORE:          imm = imm_s;
      OPC_BRANCH:         imm = imm_b;
      OPC_JAL:            imm = imm_j;
      OPC_LUI, OPC_AUIPC: imm = imm_u;
      default: ;
    endcase
  end

  assign alu_x   = (opcode == OPC_AUIPC || opcode == OPC_JAL || opcode == OPC_BRANCH) ? pc_q : rs1_val;
  assign alu_y   = (opcode == OPC_OP) ? rs2_val : imm;
  assign alu_fn  = (opcode == OPC_OP || opcode == OPC_OPIMM) ? funct3 : 3'b000;
  assign alu_alt = (opcode == OPC_OP) ? funct7[5] : (opcode == OPC_OPIMM && funct3 == 3'b101 && funct7[5]);

  // NOTE: the arithmetic shift sits in its own branch; inside a ternary with an unsigned arm it would turn logical.
  always_comb begin
    alu_res = alu_x + alu_y;
    case (alu_fn)
      3'b000: if (alu_alt) alu_res = alu_x - alu_y;
      3'b001: alu_res = alu_x << alu_y[4:0];
      3'b010: alu_res = {31'd0, $signed(alu_x) < $signed(alu_y)};
      3'b011: alu_res = {31'd0, alu_x < alu_y};
      3'b100: alu_res = alu_x ^ alu_y;
      3'b101: if (alu_alt) alu_res = $signed(alu_x) >>> alu_y[4:0];
              else         alu_res = alu_x >> alu_y[4:0];
      3'b110: alu_res = alu_x | alu_y;
      default: alu_res = alu_x & alu_y;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Sub-word accesses pick lanes by the low address bits, staying inside the addressed word.
  assign ram_d_addr   = rs1_val + imm;
  assign lane_sh      = {ram_d_addr[1:0], 3'b000};
  assign ld_shift     = ram_rdata >> lane_sh;
  assign st_data      = rs2_val << lane_sh;
  assign ram_w_enable = (opcode == OPC_STORE) && !reset;

  always_comb begin
    case (funct3[1:0])
      2'b00:   st_strb = 4'b0001 << ram_d_addr[1:0];
      2'b01:   st_strb = 4'b0011 << ram_d_addr[1:0];
      default: st_strb = 4'b1111;
    endcase
    case (funct3)
      3'b000:  load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  load_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  load_data = {24'd0, ld_shift[7:0]};
      3'b101:  load_data = {16'd0, ld_shift[15:0]};
      default: load_data = ram_rdata;
    endcase
  end

  assign is_ecall   = (instr == 32'h0000_0073);
  assign is_mret    = (instr == 32'h3020_0073);
  assign csr_funct3 = funct3;
  assign csr_addr   = instr[31:20];
  assign is_csr     = (opcode == OPC_SYSTEM) && (csr_funct3[1:0] != 2'b00);
  assign csr_data_1 = csr_funct3[2] ? {27'd0, rs1} : rs1_val;
  assign csr_re     = is_csr && !(csr_funct3[1:0] == 2'b01 && rd == 5'd0);
  assign csr_we     = is_csr && !(csr_funct3[1] && rs1 == 5'd0);

  always_comb begin
    case (csr_addr)
      12'h300:         csr_old = mstatus_q;
      12'h305:         csr_old = mtvec_q;
      12'h340:         csr_old = mscratch_q;
      12'h341:         csr_old = mepc_q;
      12'h342:         csr_old = mcause_q;
      12'hB00, 12'hC00: csr_old = cycle_q;
      default:         csr_old = 32'd0;
    endcase
    case (csr_funct3[1:0])
      2'b10:   csr_new = csr_old | csr_data_1;
      2'b11:   csr_new = csr_old & ~csr_data_1;
      default: csr_new = csr_data_1;
    endcase
  end

  always_comb begin
    wb_en     = 1'b0;
    reg_wdata = alu_res;
    pc_d      = pc_plus4;
    case (opcode)
      OPC_LUI:                       begin wb_en = 1'b1; reg_wdata = imm_u; end
      OPC_AUIPC, OPC_OP, OPC_OPIMM:  wb_en = 1'b1;
      OPC_JAL:                       begin wb_en = 1'b1; reg_wdata = pc_plus4; pc_d = alu_res; end
      OPC_JALR:                      begin wb_en = 1'b1; reg_wdata = pc_plus4; pc_d = {alu_res[31:1], 1'b0}; end
      OPC_LOAD:                      begin wb_en = 1'b1; reg_wdata = load_data; end
      OPC_BRANCH:                    if (br_taken) pc_d = alu_res;
      OPC_SYSTEM: begin
        wb_en     = csr_re;
        reg_wdata = csr_old;
        if (is_ecall)     pc_d = {mtvec_q[31:2], 2'b00};
        else if (is_mret) pc_d = mepc_q;
      end
      default: ;
    endcase
  end

  assign reg_write_idx = rd;
  assign reg_w_enable  = wb_en && (rd != 5'd0) && !reset;

  always_ff @(posedge clk) begin
    if (reg_w_enable) rf_q[reg_write_idx] <= reg_wdata;
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      mstatus_q  <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      cycle_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      cycle_q <= cycle_q + 32'd1;
      if (is_ecall) begin
        mepc_q   <= pc_q;
        mcause_q <= 32'd11;
      end else if (csr_we) begin
        case (csr_addr)
          12'h300: mstatus_q  <= csr_new;
          12'h305: mtvec_q    <= csr_new;
          12'h340: mscratch_q <= csr_new;
          12'h341: mepc_q     <= csr_new;
          12'h342: mcause_q   <= csr_new;
          default: ;
        endcase
      end
    end
  end

  assign unused_ok = ^{funct7[6], funct7[4:0], ram_d_addr[31:AW+2]};
endmodule

// File: tb/tb_rv32i_core.sv
// Self-checking bench for rv32i_core: ALU vector table, directed multi-cycle sequences,
// and random programs compared against an instruction-level reference model.

module tb_rv32i_core;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;

  rv32i_core #(.MEM_WORDS(4096), .RESET_PC(32'h0)) dut (.clk(clk), .reset_n(reset_n), .pc(pc));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_mem  [4096];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt) return $unsigned($signed(a) >>> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Instruction-level model over the bench's own copy of memory and registers.
  task automatic iss_step();
    logic [31:0] ins, a, b, ii, res, addr, word, nxt;
    logic [2:0]  f3;
    logic [1:0]  bi;
    logic        wr, take;
    ins = m_mem[m_pc[13:2]];
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    f3  = ins[14:12];
    ii  = {{20{ins[31]}}, ins[31:20]};
    nxt = m_pc + 4;
    wr  = 1'b0;
    res = 32'd0;
    case (ins[6:0])
      7'h33: begin wr = 1'b1; res = ref_alu(f3, ins[30], a, b); end
      7'h13: begin wr = 1'b1; res = ref_alu(f3, (f3 == 3'd5) && ins[30], a, ii); end
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'd0}; end
      7'h17: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'd0}; end
      7'h03: begin
        wr   = 1'b1;
        addr = a + ii;
        word = m_mem[addr[13:2]];
        bi   = addr[1:0];
        case (f3)
          3'd0: res = {{24{word[8*bi+7]}}, word[8*bi +: 8]};
          3'd4: res = {24'd0, word[8*bi +: 8]};
          3'd1: res = {{16{word[8*bi+15]}}, word[8*bi +: 16]};
          3'd5: res = {16'd0, word[8*bi +: 16]};
          default: res = word;
        endcase
      end
      7'h23: begin
        addr = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bi   = addr[1:0];
        case (f3)
          3'd0: m_mem[addr[13:2]][8*bi +: 8]  = b[7:0];
          3'd1: m_mem[addr[13:2]][8*bi +: 16] = b[15:0];
          default: m_mem[addr[13:2]] = b;
        endcase
      end
      7'h63: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a < b);
          default: take = (a >= b);
        endcase
        if (take) nxt = m_pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    m_pc = nxt;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) begin
      dut.ram.mem[i] = 32'd0;
      m_mem[i] = 32'd0;
    end
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] ins);
    dut.ram.mem[addr[13:2]] = ins;
    m_mem[addr[13:2]] = ins;
  endtask

  task automatic hold_reset();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b1;

    // ALU vectors: rs1=x1=a, rs2=x2=b, result in x3, instruction at address 0.
    vecs[0]  = '{"add",   enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h7FFF_FFFF, 32'h1,         32'h8000_0000};
    vecs[1]  = '{"sub",   enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5,         32'd7,         32'hFFFF_FFFE};
    vecs[2]  = '{"sll",   enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd3), 32'd1,         32'd33,        32'd2};
    vecs[3]  = '{"srl",   enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3), 32'h8000_0000, 32'd4,         32'h0800_0000};
    vecs[4]  = '{"sra",   enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 32'h8000_0000, 32'd4,         32'hF800_0000};
    vecs[5]  = '{"slt",   enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'hFFFF_FFFF, 32'd1,         32'd1};
    vecs[6]  = '{"sltu",  enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3), 32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[7]  = '{"xor",   enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
    vecs[8]  = '{"or",    enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3), 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F};
    vecs[9]  = '{"and",   enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3), 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000};
    vecs[10] = '{"addi",  enc_i(32'hFFF, 5'd1, 3'd0, 5'd3, 7'h13), 32'd0,      32'd0,         32'hFFFF_FFFF};
    vecs[11] = '{"srai",  enc_i(32'h41F, 5'd1, 3'd5, 5'd3, 7'h13), 32'h8000_0000, 32'd0,      32'hFFFF_FFFF};
    vecs[12] = '{"sltiu", enc_i(32'hFFF, 5'd1, 3'd3, 5'd3, 7'h13), 32'd5,      32'd0,         32'd1};
    vecs[13] = '{"lui",   {20'h12345, 5'd3, 7'h37},                32'd0,      32'd0,         32'h1234_5000};
    vecs[14] = '{"auipc", {20'h00001, 5'd3, 7'h17},                32'd0,      32'd0,         32'h0000_1000};

    // Reset and sequencing.
    clear_mem();
    put(0, enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13));
    put(4, enc_i(32'hFF9, 5'd1, 3'd0, 5'd2, 7'h13));
    put(8, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    hold_reset();
    check("pc_in_reset", pc, 32'h0);
    check("reg_we_in_reset", {31'd0, dut.reg_w_enable}, 32'd0);
    reset_n = 1'b0;
    check("pc_first", pc, 32'h0);
    step(); check("pc_edge1", pc, 32'd4);
    step(); check("pc_edge2", pc, 32'd8);
    step(); check("pc_edge3", pc, 32'd12);
    check("seq_x1", dut.rf_q[1], 32'd5);
    check("seq_x2", dut.rf_q[2], 32'hFFFF_FFFE);
    check("seq_x3", dut.rf_q[3], 32'd3);

    // Table-driven ALU vectors.
    for (int v = 0; v < 15; v++) begin
      clear_mem();
      put(0, vecs[v].instr);
      hold_reset();
      dut.rf_q[1] = vecs[v].a;
      dut.rf_q[2] = vecs[v].b;
      dut.rf_q[3] = 32'hDEAD_BEEF;
      reset_n = 1'b0;
      step();
      check(vecs[v].name, dut.rf_q[3], vecs[v].exp);
    end

    // Load/store byte lanes.
    clear_mem();
    put(0,  enc_i(32'h100, 5'd0, 3'd0, 5'd5, 7'h13));
    put(4,  enc_i(32'h080, 5'd0, 3'd0, 5'd6, 7'h13));
    put(8,  enc_s(32'd1, 5'd6, 5'd5, 3'd0));
    put(12, enc_i(32'd1, 5'd5, 3'd0, 5'd7, 7'h03));
    put(16, enc_i(32'd1, 5'd5, 3'd4, 5'd8, 7'h03));
    hold_reset(); reset_n = 1'b0;
    step(); step();
    check("sb_wen_store", {31'd0, dut.ram_w_enable}, 32'd1);
    check("sb_daddr", dut.ram_d_addr, 32'h101);
    step();
    check("sb_wen_after", {31'd0, dut.ram_w_enable}, 32'd0);
    check("sb_mem", dut.ram.mem[32'h40], 32'h0000_8000);
    step(); step();
    check("lb_x7", dut.rf_q[7], 32'hFFFF_FF80);
    check("lbu_x8", dut.rf_q[8], 32'h0000_0080);

    // Branches and jumps.
    clear_mem();
    put(0,  enc_b(32'd8, 5'd0, 5'd0, 3'd1));
    put(4,  enc_j(32'd16, 5'd1));
    put(20, enc_i(32'h021, 5'd0, 3'd0, 5'd1, 7'h13));
    put(24, enc_i(32'd0, 5'd1, 3'd0, 5'd0, 7'h67));
    hold_reset(); reset_n = 1'b0;
    step(); check("bne_not_taken", pc, 32'd4);
    step(); check("jal_pc", pc, 32'd20);
    check("jal_link", dut.rf_q[1], 32'd8);
    step(); step(); check("jalr_pc", pc, 32'h20);

    // CSR access, cycle counter and an unrecognised opcode.
    clear_mem();
    put(0,  enc_i(32'h0A5, 5'd0, 3'd0, 5'd1, 7'h13));
    put(4,  enc_i(32'h340, 5'd1, 3'd1, 5'd2, 7'h73));
    put(8,  enc_i(32'h340, 5'd0, 3'd2, 5'd3, 7'h73));
    put(12, enc_i(32'hC00, 5'd0, 3'd2, 5'd4, 7'h73));
    put(16, 32'hFFFF_FFFF);
    hold_reset(); reset_n = 1'b0;
    step(); step();
    check("csrrw_old", dut.rf_q[2], 32'd0);
    check("csrrw_mscratch", dut.mscratch_q, 32'hA5);
    check("csrrs_we", {31'd0, dut.csr_we}, 32'd0);
    check("csrrs_addr", {20'd0, dut.csr_addr}, 32'h340);
    step();
    check("csrrs_x3", dut.rf_q[3], 32'hA5);
    step();
    check("cycle_read", dut.rf_q[4], 32'd3);
    check("nop_reg_we", {31'd0, dut.reg_w_enable}, 32'd0);
    check("nop_ram_we", {31'd0, dut.ram_w_enable}, 32'd0);
    step();
    check("nop_pc", pc, 32'd20);

    // Trap round trip; mtvec low bits must be ignored for the target.
    clear_mem();
    put(0,     enc_i(32'h081, 5'd0, 3'd0, 5'd1, 7'h13));
    put(4,     enc_i(32'h305, 5'd1, 3'd1, 5'd0, 7'h73));
    put(8,     enc_i(32'd0, 5'd0, 3'd0, 5'd0, 7'h13));
    put(12,    enc_i(32'd0, 5'd0, 3'd0, 5'd0, 7'h13));
    put(16,    32'h0000_0073);
    put(32'h80, 32'h3020_0073);
    hold_reset(); reset_n = 1'b0;
    step(); step(); step(); step();
    check("pre_ecall_pc", pc, 32'h10);
    step();
    check("ecall_pc", pc, 32'h80);
    check("ecall_mepc", dut.mepc_q, 32'h10);
    check("ecall_mcause", dut.mcause_q, 32'd11);
    step();
    check("mret_pc", pc, 32'h10);

    // Asynchronous reset while a store is pending.
    clear_mem();
    put(0, enc_i(32'h200, 5'd0, 3'd0, 5'd5, 7'h13));
    put(4, enc_i(32'h055, 5'd0, 3'd0, 5'd6, 7'h13));
    put(8, enc_s(32'd0, 5'd6, 5'd5, 3'd2));
    hold_reset(); reset_n = 1'b0;
    step(); step();
    check("ar_store_pending", {31'd0, dut.ram_w_enable}, 32'd1);
    #2 reset_n = 1'b1;
    #1;
    check("ar_pc_async", pc, 32'h0);
    check("ar_wen_off", {31'd0, dut.ram_w_enable}, 32'd0);
    step();
    check("ar_no_write", dut.ram.mem[32'h80], 32'd0);
    check("ar_pc_held", pc, 32'h0);
    reset_n = 1'b0;
    step(); check("ar_restart_pc", pc, 32'd4);
    step(); step();
    check("ar_store_after", dut.ram.mem[32'h80], 32'h55);

    // Random programs checked against the instruction-level model.
    for (int it = 0; it < 3; it++) begin
      logic [2:0] lf3 [5];
      logic [2:0] bf3 [6];
      lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      clear_mem();
      hold_reset();
      m_regs[0] = 32'd0;
      for (int r = 1; r < 32; r++) begin
        m_regs[r] = (r == 10) ? 32'h800 : $urandom;
        dut.rf_q[r] = m_regs[r];
      end
      for (int w = 0; w < 16; w++) put(32'h800 + 4 * w, $urandom);
      for (int k = 0; k < 60; k++) begin
        logic [31:0] ins, off;
        logic [4:0]  rd, ra, rb;
        logic [2:0]  f3;
        rd = 5'($urandom_range(0, 9));
        ra = 5'($urandom_range(0, 9));
        rb = 5'($urandom_range(0, 9));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 6))
          0: ins = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                         rb, ra, f3, rd);
          1: begin
            if (f3 == 3'd1)      off = 32'($urandom_range(0, 31));
            else if (f3 == 3'd5) off = 32'($urandom_range(0, 31)) | ($urandom_range(0, 1) == 1 ? 32'h400 : 32'h0);
            else                 off = 32'($urandom_range(0, 4095));
            ins = enc_i(off, ra, f3, rd, 7'h13);
          end
          2: ins = {20'($urandom), rd, 7'h37};
          3: ins = {20'($urandom), rd, 7'h17};
          4, 5: begin
            f3  = lf3[$urandom_range(0, 4)];
            off = 32'($urandom_range(0, 15) * 4);
            if (f3[1:0] == 2'd0)      off = off + 32'($urandom_range(0, 3));
            else if (f3[1:0] == 2'd1) off = off + 32'(2 * $urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) ins = enc_s(off, rb, 5'd10, {1'b0, f3[1:0]});
            else                           ins = enc_i(off, 5'd10, f3, rd, 7'h03);
          end
          default: ins = enc_b(32'd8, rb, ra, bf3[$urandom_range(0, 5)]);
        endcase
        put(32'(4 * k), ins);
      end
      m_pc = 32'd0;
      reset_n = 1'b0;
      for (int s = 0; s < 70; s++) begin
        iss_step();
        step();
        check($sformatf("rand%0d_pc%0d", it, s), pc, m_pc);
      end
      for (int r = 1; r < 11; r++) check($sformatf("rand%0d_x%0d", it, r), dut.rf_q[r], m_regs[r]);
      for (int w = 0; w < 16; w++)
        check($sformatf("rand%0d_mem%0d", it, w), dut.ram.mem[12'h200 + 12'(w)], m_mem[12'h200 + 12'(w)]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
